// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe; out_flags exists only with LOGIC_FLAGS_EN.
// slave = the unit itself, master = issue logic / writeback consumer side.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef LOGIC_FLAGS_EN
    logic [2:0]       out_flags;
`endif

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
`ifdef LOGIC_FLAGS_EN
        output out_flags,
`endif
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
`ifdef LOGIC_FLAGS_EN
        input  out_flags,
`endif
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit 8-function logic unit, 2 register stages; LOGIC_FLAGS_EN adds {parity,sign,zero}.
// Latency: beat handshaken in cycle c is presented on out_data in cycle c+2; 1 beat/cycle.
// Backpressure: out_ready low holds S2 stable; S1 fills, then in_ready drops; nothing dropped.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_unit_pipe_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_OR   = 3'd0,
        OP_AND  = 3'd1,
        OP_XOR  = 3'd2,
        OP_NEG  = 3'd3,
        OP_NOR  = 3'd4,
        OP_NAND = 3'd5,
        OP_XNOR = 3'd6,
        OP_NOT  = 3'd7
    } op_e;

    logic             s1_vld_q, s1_vld_d;
    op_e              s1_op_q,  s1_op_d;
    logic [WIDTH-1:0] s1_a_q,   s1_a_d;
    logic [WIDTH-1:0] s1_b_q,   s1_b_d;
    logic             s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] s2_dat_q, s2_dat_d;
    logic [WIDTH-1:0] res;
    logic             s2_adv, s1_adv, in_xfer;

    always_comb begin
        res = '0;
        unique case (s1_op_q)
            OP_OR:   res = s1_a_q | s1_b_q;
            OP_AND:  res = s1_a_q & s1_b_q;
            OP_XOR:  res = s1_a_q ^ s1_b_q;
            OP_NEG:  res = (~s1_a_q) + {{(WIDTH-1){1'b0}}, 1'b1};
            OP_NOR:  res = ~(s1_a_q | s1_b_q);
            OP_NAND: res = ~(s1_a_q & s1_b_q);
            OP_XNOR: res = ~(s1_a_q ^ s1_b_q);
            OP_NOT:  res = ~s1_a_q;
            default: res = '0;
        endcase
    end

    // S2 frees itself when drained this cycle, which lets S1 (and the input) move in the same edge.
    always_comb begin
        s2_adv   = !s2_vld_q || bus.out_ready;
        s1_adv   = !s1_vld_q || s2_adv;
        in_xfer  = bus.in_valid && s1_adv;

        s1_vld_d = s1_vld_q;
        s1_op_d  = s1_op_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        if (s1_adv) s1_vld_d = bus.in_valid;
        if (in_xfer) begin
            s1_op_d = op_e'(bus.in_op);
            s1_a_d  = bus.in_a;
            s1_b_d  = bus.in_b;
        end

        s2_vld_d = s2_vld_q;
        s2_dat_d = s2_dat_q;
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) s2_dat_d = res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_op_q  <= OP_OR;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_dat_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_op_q  <= s1_op_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s2_vld_q <= s2_vld_d;
            s2_dat_q <= s2_dat_d;
        end
    end

`ifdef LOGIC_FLAGS_EN
    logic [2:0] s2_flg_q, s2_flg_d;

    always_comb begin
        s2_flg_d = s2_flg_q;
        if (s2_adv && s1_vld_q) s2_flg_d = {^res, res[WIDTH-1], (res == '0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s2_flg_q <= '0;
        else        s2_flg_q <= s2_flg_d;
    end

    assign bus.out_flags = s2_flg_q;
`endif

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_vld_q;
    assign bus.out_data  = s2_dat_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed + random bench for logic_unit_pipe: expected results queued on accept, checked on output.
module tb_logic_unit_pipe;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    logic_unit_pipe_if #(.WIDTH(W)) bus ();

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic [2:0]   f;
    } beat_t;

    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   f;
        int           acc;
    } exp_t;

    beat_t stim_q[$];
    exp_t  sb_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    bit rdy_fix = 1'b0;
    bit rdy_rnd = 1'b0;
    bit gap_en = 1'b0;
    bit chk_lat = 1'b0;
    bit stall_prev = 1'b0;
    logic [W-1:0] hold_d;
    logic [2:0]   hold_f;

    function automatic logic [W-1:0] golden(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] zero;
        zero = '0;
        case (op)
            3'd0:    return a | b;
            3'd1:    return a & b;
            3'd2:    return a ^ b;
            3'd3:    return zero - a;
            3'd4:    return ~(a | b);
            3'd5:    return ~(a & b);
            3'd6:    return ~(a ^ b);
            default: return ~a;
        endcase
    endfunction

    function automatic logic [2:0] gflags(input logic [W-1:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(d[i]);
        return {ones[0], d[W-1], (d == '0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] d, input logic [2:0] f);
        beat_t bt;
        bt.op = op; bt.a = a; bt.b = b; bt.d = d; bt.f = f;
        stim_q.push_back(bt);
    endtask

    task automatic push_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        push_beat(op, a, b, golden(op, a, b), gflags(golden(op, a, b)));
    endtask

    // One cycle: drive at negedge, sample 1ns later, account transfers, then advance to next negedge.
    task automatic tick();
        beat_t bt;
        exp_t  e;
        logic  acc, oxf;
        if (stim_q.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
            bt = stim_q[0];
            bus.in_valid = 1'b1;
            bus.in_op    = bt.op;
            bus.in_a     = bt.a;
            bus.in_b     = bt.b;
        end else begin
            bus.in_valid = 1'b0;
            bus.in_op    = 3'($urandom);
            bus.in_a     = W'($urandom);
            bus.in_b     = W'($urandom);
        end
        bus.out_ready = rdy_rnd ? 1'($urandom_range(1)) : rdy_fix;
        #1;
        if (stall_prev) begin
            check("hold_data", 32'(bus.out_data), 32'(hold_d));
`ifdef LOGIC_FLAGS_EN
            check("hold_flags", 32'(bus.out_flags), 32'(hold_f));
`endif
        end
        acc = bus.in_valid && bus.in_ready;
        oxf = bus.out_valid && bus.out_ready;
        if (oxf) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'(bus.out_valid), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("data", 32'(bus.out_data), 32'(e.d));
`ifdef LOGIC_FLAGS_EN
                check("flags", 32'(bus.out_flags), 32'(e.f));
`endif
                if (chk_lat) check("latency", 32'(cyc - e.acc), 32'(2));
                n_out++;
            end
        end
        if (acc) begin
            bt = stim_q.pop_front();
            e.d = bt.d; e.f = bt.f; e.acc = cyc;
            sb_q.push_back(e);
            n_acc++;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        hold_d = bus.out_data;
`ifdef LOGIC_FLAGS_EN
        hold_f = bus.out_flags;
`else
        hold_f = '0;
`endif
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((stim_q.size() > 0 || sb_q.size() > 0) && k < budget) begin
            tick();
            k++;
        end
        check("drain_done", 32'(stim_q.size() + sb_q.size()), 32'(0));
    endtask

    initial begin
        int acc0, out0;
        logic [W-1:0] ra, rb;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_data", 32'(bus.out_data), 32'(0));
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
`ifdef LOGIC_FLAGS_EN
        check("rst_out_flags", 32'(bus.out_flags), 32'(0));
`endif

        // Op sweep, back-to-back, fixed latency
        rdy_fix = 1'b1;
        chk_lat = 1'b1;
        out0 = n_out;
        push_beat(3'd0, 8'hC3, 8'h5A, 8'hDB, gflags(8'hDB));
        push_beat(3'd1, 8'hC3, 8'h5A, 8'h42, gflags(8'h42));
        push_beat(3'd2, 8'hC3, 8'h5A, 8'h99, gflags(8'h99));
        push_beat(3'd3, 8'hC3, 8'h5A, 8'h3D, gflags(8'h3D));
        push_beat(3'd4, 8'hC3, 8'h5A, 8'h24, gflags(8'h24));
        push_beat(3'd5, 8'hC3, 8'h5A, 8'hBD, gflags(8'hBD));
        push_beat(3'd6, 8'hC3, 8'h5A, 8'h66, gflags(8'h66));
        push_beat(3'd7, 8'hC3, 8'h5A, 8'h3C, gflags(8'h3C));
        drain(40);
        check("sweep_count", 32'(n_out - out0), 32'(8));

        // NEG edge cases with fixed flag patterns
        push_beat(3'd3, 8'h00, 8'hA5, 8'h00, 3'b001);
        push_beat(3'd3, 8'h80, 8'h3C, 8'h80, 3'b110);
        push_beat(3'd3, 8'h01, 8'hFF, 8'hFF, 3'b010);
        drain(30);
        chk_lat = 1'b0;

        // Backpressure: output blocked, only two beats fit
        rdy_fix = 1'b0;
        acc0 = n_acc;
        out0 = n_out;
        for (int i = 0; i < 5; i++) push_model(3'd2, W'(8'h11 * i), W'(8'h0F + i));
        repeat (4) tick();
        check("bp_accepts", 32'(n_acc - acc0), 32'(2));
        check("bp_in_ready", 32'(bus.in_ready), 32'(0));
        check("bp_out_valid", 32'(bus.out_valid), 32'(1));
        rdy_fix = 1'b1;
        drain(40);
        check("bp_out_count", 32'(n_out - out0), 32'(5));

        // Random traffic with random backpressure and input gaps
        rdy_rnd = 1'b1;
        gap_en = 1'b1;
        acc0 = n_acc;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            push_model(3'($urandom), ra, rb);
        end
        drain(20000);
        check("rand_accepts", 32'(n_acc - acc0), 32'(1000));
        rdy_rnd = 1'b0;
        gap_en = 1'b0;

        // Asynchronous reset while stalled and full
        rdy_fix = 1'b0;
        for (int i = 0; i < 4; i++) push_model(3'd0, W'(8'h21 + i), W'(8'h40));
        repeat (3) tick();
        check("pre_rst_valid", 32'(bus.out_valid), 32'(1));
        check("pre_rst_in_ready", 32'(bus.in_ready), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'(0));
        check("arst_out_data", 32'(bus.out_data), 32'(0));
`ifdef LOGIC_FLAGS_EN
        check("arst_out_flags", 32'(bus.out_flags), 32'(0));
`endif
        stim_q.delete();
        sb_q.delete();
        stall_prev = 1'b0;
        #4 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
        check("post_rst_out_valid", 32'(bus.out_valid), 32'(0));
        rdy_fix = 1'b1;
        repeat (5) tick();
        push_model(3'd7, 8'h0F, 8'h00);
        out0 = n_out;
        drain(20);
        check("post_rst_beat", 32'(n_out - out0), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
